// File: rtl/gfx_defs.sv
// Shared graphics datapath types and constants.
// Scalars are IEEE-754 single precision; vectors are packed lane arrays.
`ifndef GFX_DEFS_SV
`define GFX_DEFS_SV

`define FP_ADD_STAGES 4

package gfx_defs;

  typedef logic [31:0] fp;
  typedef fp [1:0] vec2;
  typedef fp [3:0] vec4;

  typedef enum logic [1:0] {
    NEW = 2'd0,
    FB0 = 2'd1,
    FB1 = 2'd2
  } phase_t;

endpackage

`endif

// File: rtl/horizontal_fold_ctrl.sv
// Issue-side sequencer for horizontal_fold: runs the NEW/FB0/FB1 schedule,
// tracks live slots and presents finished sums on a valid/ready stream.
module horizontal_fold_ctrl
  import gfx_defs::*;
#(
  parameter int ADD_STAGES = `FP_ADD_STAGES,
  parameter int FOLD_LAT   = ADD_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  vec4  in_vec,
  output logic out_valid,
  input  logic out_ready,
  output fp    out_q,
  output vec4  fold_vec,
  output logic fold_stall,
  output logic fold_feedback,
  output logic fold_feedback_last,
  input  fp    fold_q,
  output logic busy
);

  localparam int SW = (ADD_STAGES > 1) ? $clog2(ADD_STAGES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(ADD_STAGES - 1);

  if (FOLD_LAT != ADD_STAGES) begin : g_lat_chk
    $error("FOLD_LAT must equal ADD_STAGES");
  end
  if (ADD_STAGES < 1) begin : g_depth_chk
    $error("ADD_STAGES must be at least 1");
  end

  phase_t phase, phase_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [ADD_STAGES-1:0] occ, occ_nxt;
  logic wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot  <= '0;
      phase <= NEW;
      occ   <= '0;
    end else begin
      slot  <= slot_nxt;
      phase <= phase_nxt;
      occ   <= occ_nxt;
    end
  end

  assign wrap      = (slot == SLOT_LAST);
  assign out_valid = (phase == NEW) && occ[slot];
  assign out_q     = fold_q;
  // Any unconsumed result freezes the whole pipe so fold_q stays put.
  assign fold_stall = out_valid && !out_ready;
  assign in_ready   = (phase == NEW) && !fold_stall;
  assign busy       = |occ;

  assign fold_vec           = in_vec;
  assign fold_feedback      = (phase != NEW);
  assign fold_feedback_last = (phase == FB1);

  always_comb begin
    slot_nxt  = slot;
    phase_nxt = phase;
    occ_nxt   = occ;
    if (!fold_stall) begin
      slot_nxt = wrap ? '0 : slot + SW'(1);
      if (phase == NEW) begin
        occ_nxt[slot] = in_valid && in_ready;
      end
      if (wrap) begin
        unique case (1'b1)
          (phase == NEW): phase_nxt = FB0;
          (phase == FB0): phase_nxt = FB1;
          default:        phase_nxt = NEW;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_horizontal_fold_ctrl.sv
// Directed bench for horizontal_fold_ctrl driving a behavioural
// three-pass fold datapath model with integer-valued floats.
module tb_horizontal_fold_ctrl;
  import gfx_defs::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready;
  logic fold_stall, fold_feedback, fold_feedback_last, busy;
  vec4  in_vec, fold_vec;
  fp    out_q, fold_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  horizontal_fold_ctrl #(.ADD_STAGES(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec(in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q(out_q),
    .fold_vec(fold_vec),
    .fold_stall(fold_stall),
    .fold_feedback(fold_feedback),
    .fold_feedback_last(fold_feedback_last),
    .fold_q(fold_q),
    .busy(busy)
  );

  function automatic fp i2f(input int n);
    int e;
    logic [54:0] m;
    fp r;
    r = '0;
    e = 0;
    if (n > 0) begin
      for (int i = 0; i < 31; i++) if (n[i]) e = i;
      m = {n[31:0], 23'd0} >> e;
      r[30:23] = 8'(127 + e);
      r[22:0] = m[22:0];
    end
    return r;
  endfunction

  function automatic int f2i(input fp f);
    int e;
    logic [23:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    if (e < 0 || e > 30) return 0;
    if (e >= 23) return int'(m) << (e - 23);
    return int'(m >> (23 - e));
  endfunction

  function automatic vec4 splat(input int k);
    return {i2f(k), i2f(k), i2f(k), i2f(k)};
  endfunction

  // Datapath model: two lanes per pipe entry, N-deep, frozen on stall.
  fp pa [N];
  fp pb [N];
  fp push_a, push_b;

  always_comb begin
    push_a = '0;
    push_b = '0;
    if (!fold_feedback) begin
      push_a = i2f(f2i(fold_vec[0]) + f2i(fold_vec[1]));
      push_b = i2f(f2i(fold_vec[2]) + f2i(fold_vec[3]));
    end else if (!fold_feedback_last) begin
      push_a = i2f(f2i(pa[N-1]) + f2i(pb[N-1]));
    end else begin
      push_a = pa[N-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else if (!fold_stall) begin
      pa[0] <= push_a;
      pb[0] <= push_b;
      for (int i = 1; i < N; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign fold_q = pa[N-1];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_vec = '0;
    tick();
    tick();
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", fold_stall, 0);
    check("rst_fb", fold_feedback, 0);
    check("rst_fbl", fold_feedback_last, 0);
    rst = 1'b0;
  endtask

  logic [31:0] e2 [4] = '{32'h40800000, 32'h41000000,
                          32'h41400000, 32'h41800000};
  int  sums [64];
  bit  acc [64];

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_vec = '0;

    // single vector
    reset_dut();
    for (int c = 0; c < 16; c++) begin
      in_valid = (c == 0);
      in_vec = {i2f(4), i2f(3), i2f(2), i2f(1)};
      #1;
      if (c == 0) begin
        check("t1_rdy", in_ready, 1);
        check("t1_vec", fold_vec[2], 32'h40400000);
      end
      if (c == 4) begin
        check("t1_fb0", fold_feedback, 1);
        check("t1_fbl0", fold_feedback_last, 0);
      end
      if (c == 8) check("t1_fbl1", fold_feedback_last, 1);
      check($sformatf("t1_ov c%0d", c), out_valid, c == 12);
      check($sformatf("t1_busy c%0d", c), busy, c >= 1 && c <= 12);
      if (c == 12) check("t1_q", out_q, 32'h41200000);
      tick();
    end

    // full burst
    reset_dut();
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 4);
      in_vec = splat(c + 1);
      #1;
      check($sformatf("t2_rdy c%0d", c), in_ready, c < 4 || c >= 12);
      check($sformatf("t2_ov c%0d", c), out_valid, c >= 12);
      if (c >= 12) check($sformatf("t2_q c%0d", c), out_q, e2[c-12]);
      tick();
    end

    // bubbles in slots 1 and 3
    reset_dut();
    for (int c = 0; c < 16; c++) begin
      in_valid = (c == 0 || c == 2);
      in_vec = (c == 0) ? {i2f(5), i2f(4), i2f(3), i2f(2)}
                        : {i2f(2), i2f(2), i2f(1), i2f(1)};
      #1;
      check($sformatf("t3_ov c%0d", c), out_valid, c == 12 || c == 14);
      if (c == 12) check("t3_q0", out_q, 32'h41600000);
      if (c == 14) check("t3_q2", out_q, 32'h40C00000);
      tick();
    end

    // backpressure on the first result
    reset_dut();
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 4);
      in_vec = splat(c + 1);
      out_ready = !(c >= 12 && c <= 16);
      #1;
      check($sformatf("t4_ov c%0d", c), out_valid, c >= 12 && c <= 20);
      check($sformatf("t4_stall c%0d", c), fold_stall, c >= 12 && c <= 16);
      if (c >= 12 && c <= 17) check($sformatf("t4_rdy c%0d", c), in_ready, c == 17);
      if (c >= 12 && c <= 20)
        check($sformatf("t4_q c%0d", c), out_q, e2[(c <= 17) ? 0 : c - 17]);
      tick();
    end
    out_ready = 1'b1;

    // continuous input stream
    reset_dut();
    begin
      int n;
      bit rdy;
      n = 0;
      for (int c = 0; c < 64; c++) acc[c] = 1'b0;
      for (int c = 0; c < 56; c++) begin
        in_valid = (c < 40);
        in_vec = {i2f(n + 3), i2f(n + 2), i2f(n + 1), i2f(n + 1)};
        #1;
        rdy = ((c / 4) % 3) == 0;
        check($sformatf("t5_rdy c%0d", c), in_ready, rdy);
        if (c >= 12) begin
          check($sformatf("t5_ov c%0d", c), out_valid, acc[c-12]);
          if (acc[c-12])
            check($sformatf("t5_q c%0d", c), out_q, i2f(sums[c-12]));
        end
        if (c == 12) check("t5_first", out_q, 32'h40E00000);
        if (rdy && c < 40) begin
          sums[c] = 4 * n + 7;
          acc[c] = 1'b1;
          n++;
        end
        tick();
      end
    end

    // reset in the middle of FB0
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_vec = splat(c + 1);
      #1;
      if (c >= 1) check($sformatf("t6_busy c%0d", c), busy, 1);
      if (c == 7) check("t6_fb", fold_feedback, 1);
      if (c < 7) tick();
    end
    rst = 1'b1;
    #1;
    check("t6_rst_ov", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_fb", fold_feedback, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b0;
      #1;
      check($sformatf("t6_ov c%0d", c), out_valid, 0);
      check($sformatf("t6_busy2 c%0d", c), busy, 0);
      if (c < 4) check($sformatf("t6_rdy c%0d", c), in_ready, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/horizontal_fold_ctrl.md
# horizontal_fold_ctrl

Issue-side sequencer for `horizontal_fold`. It accepts `vec4` operands on a valid/ready stream and drives the fold datapath's `vec`, `stall`, `feedback` and `feedback_last` controls in the three-pass schedule that the datapath expects. It tracks which pipeline slots hold live work and presents each completed scalar sum on a valid/ready output stream. It sits between a shader-core reduction request (dot product, length) and the `fp` result consumer.

## Interface

Parameters:
- `ADD_STAGES`, default `` `FP_ADD_STAGES ``: depth of the `fp_add` pipeline inside the fold datapath. Must be ≥1.
- `FOLD_LAT`, default `ADD_STAGES`: non-stalled cycles from an issue to the corresponding value appearing on `fold_q`. Fixed equal to `ADD_STAGES`; any other value is rejected by an elaboration assertion.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input operand present.
- `in_ready`  out  1  operand accepted this cycle when `in_valid && in_ready`.
- `in_vec`  in  `vec4`  operand to reduce.
- `out_valid`  out  1  `out_q` holds a finished sum.
- `out_ready`  in  1  consumer takes `out_q`.
- `out_q`  out  `fp`  sum `v0+v1+v2+v3`.
- `fold_vec`  out  `vec4`  to datapath `vec`.
- `fold_stall`  out  1  to datapath `stall`.
- `fold_feedback`  out  1  to datapath `feedback`.
- `fold_feedback_last`  out  1  to datapath `feedback_last`.
- `fold_q`  in  `fp`  from datapath `q`.
- `busy`  out  1  at least one vector is in flight.

## Operation

Schedule state:
- `slot` counter, 0..`ADD_STAGES`-1.
- `phase`: `NEW` → `FB0` → `FB1` → `NEW`. `phase` advances when `slot` wraps from `ADD_STAGES`-1 to 0.
- `slot` and `phase` advance only on cycles with `!fold_stall`.

Datapath controls:
- `fold_feedback = (phase != NEW)`.
- `fold_feedback_last = (phase == FB1)`.
- `fold_vec = in_vec`, passed through combinationally. The datapath ignores it outside `NEW`.

Occupancy:
- `occ[ADD_STAGES]` holds one live bit per slot.
- In phase `NEW`, slot `s`, unstalled: `occ[s] <= (in_valid && in_ready)`.
- In `FB0` and `FB1`, `occ` is held.

Output:
- `out_valid = (phase == NEW) && occ[slot]`.
- `out_q = fold_q`.
- The value on `fold_q` in `NEW`/`s` is the result of the `FB1`/`s` issue.

Input and flow control:
- `in_ready = (phase == NEW) && !fold_stall`.
- `fold_stall = out_valid && !out_ready`. A stall freezes the counters, `occ`, and the whole datapath, so `out_q` holds stable.
- `busy = |occ`.

Boundary conditions:
- **Completion and new issue in the same `NEW` slot:** both happen. The old result is presented and the new vector's bit overwrites `occ[s]` in the same edge.
- **Empty slots:** a missing `in_valid` in a `NEW` slot leaves a bubble (`occ[s]=0`). A bubble never produces `out_valid`.
- **`in_valid` during `FB0`/`FB1`:** held off (`in_ready=0`). The source must keep `in_vec` stable (standard valid/ready).
- **Output backpressure:** `out_ready` low with `out_valid` high stalls everything, including acceptance of a vector in the same slot.
- **Reset mid-operation:** asynchronously clears `slot`, `phase` and `occ`. In-flight sums are discarded, and no spurious `out_valid` follows.

## Timing

Reset values:
- `slot=0`, `phase=NEW`, `occ=0`.
- Outputs: `out_valid=0`, `busy=0`, `fold_stall=0`, `fold_feedback=0`, `fold_feedback_last=0`.
- `in_ready=1` from the first cycle after `rst` deasserts.

Latency and throughput:
- **Latency:** a vector accepted at unstalled cycle t raises `out_valid` at unstalled cycle t+3·`ADD_STAGES`, in the same slot index. Stalled cycles add one-for-one.
- **Throughput:** `ADD_STAGES` vectors per 3·`ADD_STAGES` cycles, i.e. 1/3 per cycle peak. The maximum burst is `ADD_STAGES` back-to-back accepts, then 2·`ADD_STAGES` cycles with `in_ready=0`.
- **Ordering:** results emerge in acceptance order.

## Structure

- `phase` enum (`NEW`, `FB0`, `FB1`) goes in `gfx_defs.sv` alongside `vec4`, `vec2` and `fp`.
- Reuse `` `FP_ADD_STAGES `` from `gfx_defs.sv`; define no new constants.
- No sub-module is required. The slot/phase counter with `occ` is one `always_ff` with async reset.
- The bench top is `horizontal_fold_ctrl` wired to `horizontal_fold`.

## Test plan

Use `ADD_STAGES=4` and `out_ready=1` unless stated.

1. **Single vector:** `in_vec=(1.0,2.0,3.0,4.0)` at cycle 0 → `out_valid` exactly once at cycle 12, `out_q=10.0`. `busy=1` for cycles 1–12.
2. **Full burst:** 4 vectors `(k,k,k,k)` for k=1..4, issued back-to-back → `in_ready` drops for cycles 4–11; outputs 4.0, 8.0, 12.0, 16.0 on cycles 12–15.
3. **Bubble pattern:** issue only in slots 0 and 2 → `out_valid` only in slots 0 and 2 of the next `NEW` phase, with correct sums.
4. **Backpressure:** hold `out_ready=0` for 5 cycles at the first result → `fold_stall=1`, `out_q` stable, no accept; after release, the remaining results follow in order with latency +5.
5. **Overlap:** continuous `in_valid` for 40 cycles → every result matches its input order, and each `NEW` slot both emits and accepts.
6. **Mid-flight reset:** assert `rst` at cycle 7 after a burst → `out_valid=0` and `busy=0` immediately; no result appears afterward; `in_ready=1` after release.
